clkout_divider_bank: RTL and testbench

- Parametrised single-clock bank of NUM_CH programmable clock-enable/divided-clock generators. Each channel has a divide ratio, a phase offset and a free-running tick counter.
- Has a lock state machine modelled on a PLL startup: outputs are gated until the configuration has been stable for LOCK_CYCLES.
- Used as a synthesisable stand-in for PLL CLKOUTn fan-out in timing-constraint test designs. Also used as a generic multi-rate enable source for counter fabrics.

---
 rtl/clkout_divider_bank.sv | 150 +++++++++++++++
 tb/tb_clkout_divider_bank.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/clkout_divider_bank.sv
// clkout_divider_bank: a bank of NUM_CH programmable divided-clock / tick
// generators. A lock FSM modelled on a PLL startup keeps every output
// gated until the shadowed configuration has been stable for LOCK_CYCLES.
module clkout_divider_bank #(
   parameter int NUM_CH      = 4,
   parameter int DIV_WIDTH   = 8,
   parameter int CNT_WIDTH   = 2,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          cfg_load_i,
   input  logic [NUM_CH*DIV_WIDTH-1:0]   div_i,
   input  logic [NUM_CH*DIV_WIDTH-1:0]   phase_i,
   input  logic [NUM_CH-1:0]             ch_en_i,
   output logic [NUM_CH-1:0]             clkout_o,
   output logic [NUM_CH-1:0]             tick_o,
   output logic [NUM_CH*CNT_WIDTH-1:0]   tick_cnt_o,
   output logic                          locked_o
);

   // Lock counter must be able to hold LOCK_CYCLES itself (it counts one
   // past the terminal value on the transition edge).
   localparam int LCW = $clog2(LOCK_CYCLES + 1);

   typedef enum logic {
      WAIT_LOCK = 1'b0,
      LOCKED    = 1'b1
   } state_e;

   typedef logic [DIV_WIDTH-1:0] dfield_t;

   // De = max(div, 2): ratios 0 and 1 degrade to the fastest legal rate.
   function automatic dfield_t eff_div(input dfield_t d);
      return (d < dfield_t'(2)) ? dfield_t'(2) : d;
   endfunction

   // Pe = min(phase, De-1): an out-of-range offset parks on the last count.
   function automatic dfield_t eff_phase(input dfield_t d, input dfield_t p);
      dfield_t de;
      de = eff_div(d);
      return (p > de - dfield_t'(1)) ? de - dfield_t'(1) : p;
   endfunction

   state_e                              state_q, state_d;
   logic [LCW-1:0]                      lock_cnt_q, lock_cnt_d;
   logic [NUM_CH-1:0][DIV_WIDTH-1:0]    div_q, phase_q;
   logic [NUM_CH-1:0][DIV_WIDTH-1:0]    div_v, phase_v;
   logic [NUM_CH-1:0][DIV_WIDTH-1:0]    cnt_q, cnt_d;
   logic [NUM_CH-1:0]                   clkout_q, clkout_d;
   logic [NUM_CH-1:0]                   tick_q, tick_d;
   logic [NUM_CH-1:0][CNT_WIDTH-1:0]    tick_cnt_q, tick_cnt_d;

   assign div_v   = div_i;
   assign phase_v = phase_i;

   // Lock FSM state and lock counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= WAIT_LOCK;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // Lock FSM next state: count out LOCK_CYCLES, a config load restarts it.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      case (state_q)
         WAIT_LOCK: begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
            if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) state_d = LOCKED;
         end
         LOCKED:    lock_cnt_d = lock_cnt_q;
         default:   state_d = WAIT_LOCK;
      endcase
      // A load wins over lock completion landing in the same cycle.
      if (cfg_load_i) begin
         state_d    = WAIT_LOCK;
         lock_cnt_d = '0;
      end
   end

   // Shadow configuration; live div/phase inputs only matter on a load.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i]   <= dfield_t'(2);
            phase_q[i] <= '0;
         end
      end else if (cfg_load_i) begin
         div_q   <= div_v;
         phase_q <= phase_v;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      dfield_t de, pe, pe_new;
      logic    run;

      assign de     = eff_div(div_q[g]);
      assign pe     = eff_phase(div_q[g], phase_q[g]);
      assign pe_new = eff_phase(div_v[g], phase_v[g]);
      assign run    = (state_q == LOCKED) && ch_en_i[g] && !cfg_load_i;

      // Channel next state: count modulo De while running, else park on Pe.
      always_comb begin
         cnt_d[g]      = cnt_q[g];
         clkout_d[g]   = 1'b0;
         tick_d[g]     = 1'b0;
         // tick_cnt trails tick by one edge: it counts ticks already shown.
         tick_cnt_d[g] = tick_cnt_q[g] + CNT_WIDTH'(tick_q[g]);
         if (cfg_load_i) begin
            // Park on the incoming offset so the counter agrees with the
            // shadow that is being written on this same edge.
            cnt_d[g] = pe_new;
         end else if (!run) begin
            cnt_d[g] = pe;
         end else begin
            cnt_d[g]    = (cnt_q[g] >= de - dfield_t'(1)) ? '0 : cnt_q[g] + dfield_t'(1);
            clkout_d[g] = (cnt_q[g] < (de >> 1));
            tick_d[g]   = (cnt_q[g] == '0);
         end
      end

      // Channel registers.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            cnt_q[g]      <= '0;
            clkout_q[g]   <= 1'b0;
            tick_q[g]     <= 1'b0;
            tick_cnt_q[g] <= '0;
         end else begin
            cnt_q[g]      <= cnt_d[g];
            clkout_q[g]   <= clkout_d[g];
            tick_q[g]     <= tick_d[g];
            tick_cnt_q[g] <= tick_cnt_d[g];
         end
      end
   end

   assign clkout_o   = clkout_q;
   assign tick_o     = tick_q;
   assign tick_cnt_o = tick_cnt_q;
   assign locked_o   = (state_q == LOCKED);

endmodule

// File: tb/tb_clkout_divider_bank.sv
// Bench for clkout_divider_bank: directed table around the first lock,
// hand sequences for load/enable/reset corners, then random traffic
// against a cycle-level arithmetic reference model.
module tb_clkout_divider_bank;
   localparam int NC = 4;
   localparam int DW = 8;
   localparam int CW = 2;
   localparam int LC = 16;

   logic              clk = 1'b0;
   logic              rst, cfg_load;
   logic [NC*DW-1:0]  div, phase;
   logic [NC-1:0]     ch_en;
   logic [NC-1:0]     clkout, tick;
   logic [NC*CW-1:0]  tick_cnt;
   logic              locked;

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;

   always #5 clk = ~clk;

   clkout_divider_bank #(.NUM_CH(NC), .DIV_WIDTH(DW), .CNT_WIDTH(CW), .LOCK_CYCLES(LC)) dut (
      .clk_i(clk), .rst_i(rst), .cfg_load_i(cfg_load), .div_i(div), .phase_i(phase),
      .ch_en_i(ch_en), .clkout_o(clkout), .tick_o(tick), .tick_cnt_o(tick_cnt), .locked_o(locked)
   );

   // Reference model: lock age in cycles, and per channel the number of
   // cycles counted since the counter last sat on its offset.
   int m_div[NC], m_ph[NC], m_k[NC], m_tc[NC];
   bit m_clk[NC], m_tick[NC];
   bit m_locked;
   int m_age;

   function automatic int de_of(int d);
      return (d < 2) ? 2 : d;
   endfunction
   function automatic int pe_of(int d, int p);
      return (p > de_of(d) - 1) ? de_of(d) - 1 : p;
   endfunction

   task automatic model_step();
      int c;
      if (rst) begin
         m_locked = 0; m_age = 0;
         for (int i = 0; i < NC; i++) begin
            m_div[i] = 2; m_ph[i] = 0; m_k[i] = 0; m_tc[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
         end
         return;
      end
      for (int i = 0; i < NC; i++) begin
         bit run;
         m_tc[i] = (m_tc[i] + int'(m_tick[i])) % (1 << CW);
         run = m_locked && ch_en[i] && !cfg_load;
         c = (pe_of(m_div[i], m_ph[i]) + m_k[i]) % de_of(m_div[i]);
         m_clk[i]  = run && (c < de_of(m_div[i]) / 2);
         m_tick[i] = run && (c == 0);
         m_k[i] = run ? (m_k[i] + 1) % de_of(m_div[i]) : 0;
      end
      if (cfg_load) begin
         for (int i = 0; i < NC; i++) begin
            m_div[i] = int'(div[i*DW +: DW]); m_ph[i] = int'(phase[i*DW +: DW]);
         end
         m_age = 0; m_locked = 0;
      end else if (!m_locked) begin
         m_age++;
         if (m_age == LC) m_locked = 1;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // One clock: apply current inputs, advance model, compare away from the edge.
   task automatic step();
      logic [NC-1:0] ec, et;
      logic [NC*CW-1:0] etc;
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      for (int i = 0; i < NC; i++) begin
         ec[i] = m_clk[i]; et[i] = m_tick[i]; etc[i*CW +: CW] = CW'(m_tc[i]);
      end
      chk("model_clkout", 32'(clkout), 32'(ec));
      chk("model_tick", 32'(tick), 32'(et));
      chk("model_tick_cnt", 32'(tick_cnt), 32'(etc));
      chk("model_locked", 32'(locked), 32'(m_locked));
   endtask

   typedef struct {
      int         n;
      logic       lk;
      logic [3:0] ck;
      logic [3:0] tk;
      logic [1:0] tc0;
   } vec_t;
   vec_t tbl[9];

   initial begin
      // Cycles counted from the cfg_load edge (n=0). Config:
      // ch0 D4 P0, ch1 D5 P2, ch2 D0 (->2), ch3 D6 P200 (->5).
      tbl[0] = '{15, 1'b0, 4'b0000, 4'b0000, 2'd0};
      tbl[1] = '{16, 1'b1, 4'b0000, 4'b0000, 2'd0};
      tbl[2] = '{17, 1'b1, 4'b0101, 4'b0101, 2'd0};
      tbl[3] = '{18, 1'b1, 4'b1001, 4'b1000, 2'd1};
      tbl[4] = '{19, 1'b1, 4'b1100, 4'b0100, 2'd1};
      tbl[5] = '{20, 1'b1, 4'b1010, 4'b0010, 2'd1};
      tbl[6] = '{21, 1'b1, 4'b0111, 4'b0101, 2'd1};
      tbl[7] = '{22, 1'b1, 4'b0001, 4'b0000, 2'd2};
      tbl[8] = '{29, 1'b1, 4'b0101, 4'b0101, 2'd3};

      rst = 1'b1; cfg_load = 1'b0; ch_en = '1;
      div = {8'd6, 8'd0, 8'd5, 8'd4}; phase = {8'd200, 8'd0, 8'd2, 8'd0};
      step();
      chk("reset_outputs", {clkout, tick, tick_cnt, 7'(locked)}, '0);
      rst = 1'b0;
      repeat (3) step();

      // Directed first lock.
      cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      for (int n = 1; n <= 34; n++) begin
         step();
         foreach (tbl[t]) if (tbl[t].n == n) begin
            chk("tbl_locked", 32'(locked), 32'(tbl[t].lk));
            chk("tbl_clkout", 32'(clkout), 32'(tbl[t].ck));
            chk("tbl_tick", 32'(tick), 32'(tbl[t].tk));
            chk("tbl_tick_cnt0", 32'(tick_cnt[1:0]), 32'(tbl[t].tc0));
         end
         // ch0 wraps its 2-bit tick count after four ticks (j=16 -> n=33).
         if (n == 33) chk("tick_cnt0_wrap", 32'(tick_cnt[1:0]), 32'd0);
      end

      // ch_en[0] dropped for three cycles: ch0 silent, others unaffected.
      ch_en = 4'b1110;
      for (int n = 0; n < 3; n++) begin
         step();
         chk("en_gap_ch0", 32'({clkout[0], tick[0]}), 32'd0);
      end
      ch_en = '1;
      repeat (12) step();

      // Mid-run load: locked low and every output quiet through the relock.
      div = {8'd3, 8'd1, 8'd7, 8'd9}; phase = {8'd1, 8'd0, 8'd6, 8'd4};
      cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      div = '1; phase = '1;
      for (int n = 1; n <= 16; n++) begin
         step();
         chk("reload_quiet", 32'({clkout, tick, 7'(locked)}), n == 16 ? 32'd1 : 32'd0);
      end
      repeat (20) step();

      // Reset together with cfg_load: load ignored, defaults D2 P0 return.
      rst = 1'b1; cfg_load = 1'b1; div = {4{8'd9}}; phase = {4{8'd3}};
      step();
      chk("rst_cfg_outputs", {clkout, tick, tick_cnt, 7'(locked)}, '0);
      rst = 1'b0; cfg_load = 1'b0;
      repeat (16) step();
      step();
      chk("rst_default_clkout", 32'(clkout), 32'hF);
      chk("rst_default_tick", 32'(tick), 32'hF);

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         rst      = ($urandom_range(0, 599) == 0);
         cfg_load = ($urandom_range(0, 59) == 0);
         for (int i = 0; i < NC; i++) begin
            div[i*DW +: DW]   = ($urandom_range(0, 7) == 0) ? DW'($urandom) : DW'($urandom_range(0, 9));
            phase[i*DW +: DW] = ($urandom_range(0, 7) == 0) ? DW'($urandom) : DW'($urandom_range(0, 10));
            if ($urandom_range(0, 15) == 0) ch_en[i] = ~ch_en[i];
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
